// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response, execute redirect and decode hand-off.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        next_valid;
  logic        next_ready;
  logic [31:0] next_inst;
  logic [31:0] next_pc;

  modport master (
    output imem_req_valid, imem_req_addr, next_valid, next_inst, next_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, next_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, next_valid, next_inst, next_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, next_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: credit-limited word fetch, in-order instruction queue, redirect flush with
// drop of in-flight responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master fif
);
  localparam int unsigned PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned SUM_W    = CNT_W + 1;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        last_pc_q, last_pc_d;
  logic [CNT_W-1:0]   out_q, out_d;
  logic [CNT_W-1:0]   disc_q, disc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [PTR_W-1:0]   pf_rd_q, pf_rd_d, pf_wr_q, pf_wr_d;
  logic               req_en_q;

  logic [31:0]        q_inst [QUEUE_DEPTH];
  logic [31:0]        q_pc   [QUEUE_DEPTH];
  logic [31:0]        pf_pc  [QUEUE_DEPTH];

  logic               resp_take, pop, req_valid, accept, push;
  logic [SUM_W-1:0]   used;

  // A slot freed by this cycle's pop already counts as credit, so 1-cycle memory sustains full rate.
  always_comb begin
    resp_take = fif.imem_resp_valid && (out_q != '0);
    pop       = (cnt_q != '0) && fif.next_ready;
    used      = SUM_W'(out_q) + SUM_W'(cnt_q) - SUM_W'(pop);
    req_valid = req_en_q && (state_q == RUN) && !fif.redirect_valid &&
                (used < SUM_W'(QUEUE_DEPTH));
    accept    = req_valid && fif.imem_req_ready;
  end

  assign fif.imem_req_valid = req_valid;
  assign fif.imem_req_addr  = pc_q;
  assign fif.next_valid     = (cnt_q != '0);
  assign fif.next_inst      = (cnt_q != '0) ? q_inst[rd_q] : NOP_INST;
  assign fif.next_pc        = (cnt_q != '0) ? q_pc[rd_q]   : last_pc_q;

  // Next-state: redirect flushes everything and converts in-flight responses into discards.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    last_pc_d = last_pc_q;
    out_d     = out_q + CNT_W'(accept) - CNT_W'(resp_take);
    disc_d    = disc_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    pf_rd_d   = pf_rd_q;
    pf_wr_d   = pf_wr_q;
    push      = 1'b0;

    if (fif.redirect_valid) begin
      pc_d    = fif.redirect_pc & ~32'h0000_0003;
      disc_d  = out_q - CNT_W'(resp_take);
      out_d   = out_q - CNT_W'(resp_take);
      cnt_d   = '0;
      rd_d    = '0;
      wr_d    = '0;
      pf_rd_d = '0;
      pf_wr_d = '0;
      state_d = (disc_d != '0) ? DRAIN : RUN;
    end else begin
      if (accept) begin
        pc_d    = pc_q + 32'd4;
        pf_wr_d = pf_wr_q + PTR_W'(1);
      end
      if (resp_take) begin
        if (disc_q != '0) begin
          disc_d = disc_q - CNT_W'(1);
        end else begin
          push    = 1'b1;
          wr_d    = wr_q + PTR_W'(1);
          pf_rd_d = pf_rd_q + PTR_W'(1);
        end
      end
      if (pop) begin
        rd_d      = rd_q + PTR_W'(1);
        last_pc_d = q_pc[rd_q];
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      if (state_q == DRAIN && disc_d == '0) state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      last_pc_q <= RESET_PC;
      out_q     <= '0;
      disc_q    <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      pf_rd_q   <= '0;
      pf_wr_q   <= '0;
      req_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      last_pc_q <= last_pc_d;
      out_q     <= out_d;
      disc_q    <= disc_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      pf_rd_q   <= pf_rd_d;
      pf_wr_q   <= pf_wr_d;
      req_en_q  <= 1'b1;
    end
  end

  // Queue and request-PC storage; writes are gated off while in reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_q] <= fif.imem_resp_data;
      q_pc[wr_q]   <= pf_pc[pf_rd_q];
    end
    if (accept) pf_pc[pf_wr_q] <= pc_q;
  end
endmodule
